// File: rtl/maj_net_eval_if.sv
// ---------------------------------------------------------------------------
// maj_net_eval_if
// Bus bundle for the majority-network evaluator.
//   master : drives configuration writes and evaluation requests
//            (cfg_we, cfg_addr, cfg_data, start, mode, x_in) and observes
//            status/results (busy, done, out_bit, tt).
//   slave  : the evaluator side, with the directions reversed.
// Widths follow the evaluator parameters:
//   SEL_W = operand select width, AW = program address width,
//   DW = program word width {inv_c,sel_c,inv_b,sel_b,inv_a,sel_a}.
// ---------------------------------------------------------------------------
interface maj_net_eval_if #(
    parameter int N_IN    = 7,
    parameter int N_NODES = 5
);
    localparam int SEL_W = $clog2(1 + N_IN + N_NODES);
    localparam int AW    = (N_NODES > 1) ? $clog2(N_NODES) : 1;
    localparam int DW    = 3 * (SEL_W + 1);

    logic                 cfg_we;
    logic [AW-1:0]        cfg_addr;
    logic [DW-1:0]        cfg_data;
    logic                 start;
    logic                 mode;
    logic [N_IN-1:0]      x_in;
    logic                 busy;
    logic                 done;
    logic                 out_bit;
    logic [2**N_IN-1:0]   tt;

    modport master (
        output cfg_we, cfg_addr, cfg_data, start, mode, x_in,
        input  busy, done, out_bit, tt
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, start, mode, x_in,
        output busy, done, out_bit, tt
    );
endinterface

// File: rtl/maj_net_eval.sv
// ---------------------------------------------------------------------------
// maj_net_eval
// Iterative evaluator for a programmable network of 3-input majority nodes.
// One node is evaluated per clock. Single mode returns f(x_in); sweep mode
// walks every input assignment and fills the full truth table.
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   bus     : maj_net_eval_if.slave
//             cfg_we/cfg_addr/cfg_data : program-word write (IDLE only)
//             start/mode/x_in          : evaluation request (IDLE only)
//             busy/done                : status, done is a one-cycle pulse
//             out_bit/tt               : results, held until next completion
// ---------------------------------------------------------------------------
module maj_net_eval #(
    parameter int N_IN    = 7,
    parameter int N_NODES = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    maj_net_eval_if.slave  bus
);
    localparam int SEL_W = $clog2(1 + N_IN + N_NODES);
    localparam int AW    = (N_NODES > 1) ? $clog2(N_NODES) : 1;
    localparam int NSRC  = 1 + N_IN + N_NODES;
    localparam int SRC_W = 2**SEL_W;

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

    typedef struct packed {
        logic             inv_c;
        logic [SEL_W-1:0] sel_c;
        logic             inv_b;
        logic [SEL_W-1:0] sel_b;
        logic             inv_a;
        logic [SEL_W-1:0] sel_a;
    } op_word_t;

    state_t             state_q, state_d;
    op_word_t           prog_q [N_NODES];
    logic [N_NODES-1:0] node_q;
    logic [AW-1:0]      ctr_q;
    logic [N_IN-1:0]    asg_q;
    logic [N_IN-1:0]    x_q;
    logic               mode_q;
    logic               out_bit_q;
    logic [2**N_IN-1:0] tt_q;

    // Operand fabric: index 0 is constant 0, then inputs, then node values.
    // Indices past the last node land in the zero-filled upper part.
    logic [N_IN-1:0]    x_cur;
    logic [SRC_W-1:0]   src;
    op_word_t           word;
    logic               op_a, op_b, op_c, node_res;
    logic               last_node, last_asg, wr_ok;

    assign x_cur = mode_q ? asg_q : x_q;

    // NOTE: every signal assigned in an always_comb gets a default first,
    // otherwise an uncovered path infers a latch.
    always_comb begin
        src           = '0;
        src[NSRC-1:0] = {node_q, x_cur, 1'b0};
    end

    assign word      = prog_q[ctr_q];
    assign op_a      = src[word.sel_a] ^ word.inv_a;
    assign op_b      = src[word.sel_b] ^ word.inv_b;
    assign op_c      = src[word.sel_c] ^ word.inv_c;
    assign node_res  = (op_a & op_b) | (op_a & op_c) | (op_b & op_c);

    assign last_node = (int'(ctr_q) == N_NODES - 1);
    assign last_asg  = &asg_q;
    assign wr_ok     = bus.cfg_we && (state_q == S_IDLE) && (int'(bus.cfg_addr) < N_NODES);

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.start) state_d = S_EVAL;
            S_EVAL:  if (last_node && (!mode_q || last_asg)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: program memory, node values, counters and results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the program memory is reset explicitly; a reset must leave
            // the network computing constant 0, so it cannot be left as RAM.
            for (int k = 0; k < N_NODES; k++) prog_q[k] <= '0;
            node_q    <= '0;
            ctr_q     <= '0;
            asg_q     <= '0;
            x_q       <= '0;
            mode_q    <= 1'b0;
            out_bit_q <= 1'b0;
            tt_q      <= '0;
        end else begin
            // A same-edge write and start both land; EVAL reads the new word.
            if (wr_ok) prog_q[bus.cfg_addr] <= bus.cfg_data;

            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        mode_q <= bus.mode;
                        x_q    <= bus.x_in;
                        asg_q  <= '0;
                        ctr_q  <= '0;
                        node_q <= '0;
                    end
                end
                S_EVAL: begin
                    node_q[ctr_q] <= node_res;
                    if (!last_node) begin
                        ctr_q <= ctr_q + 1'b1;
                    end else if (!mode_q) begin
                        out_bit_q <= node_res;
                    end else begin
                        tt_q[asg_q] <= node_res;
                        if (last_asg) begin
                            out_bit_q <= node_res;
                        end else begin
                            // Later assignment wins over the node write above:
                            // the next assignment starts from all-zero nodes.
                            asg_q  <= asg_q + 1'b1;
                            node_q <= '0;
                            ctr_q  <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state_q == S_EVAL);
    assign bus.done    = (state_q == S_DONE);
    assign bus.out_bit = out_bit_q;
    assign bus.tt      = tt_q;
endmodule

// File: tb/tb_maj_net_eval.sv
// ---------------------------------------------------------------------------
// tb_maj_net_eval
// Self-checking bench for maj_net_eval. A behavioural model evaluates the
// network from the program words (majority = at least two operands high)
// and supplies every expected out_bit / tt value.
// Cycle numbering: cycle 1 is the clock period that follows the edge which
// samples start, so single-mode done appears in cycle N_NODES+1.
// ---------------------------------------------------------------------------
module tb_maj_net_eval;
    localparam int N_IN    = 7;
    localparam int N_NODES = 5;
    localparam int SEL_W   = $clog2(1 + N_IN + N_NODES);
    localparam int AW      = (N_NODES > 1) ? $clog2(N_NODES) : 1;
    localparam int DW      = 3 * (SEL_W + 1);
    localparam int TTW     = 2**N_IN;
    localparam int LAT_SINGLE = N_NODES + 1;
    localparam int LAT_SWEEP  = TTW * N_NODES + 1;
    localparam int LIMIT      = LAT_SWEEP + 50;

    logic clk = 1'b0;
    logic rst_n;

    maj_net_eval_if #(.N_IN(N_IN), .N_NODES(N_NODES)) bus();

    maj_net_eval #(.N_IN(N_IN), .N_NODES(N_NODES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int            n_vec = 0;
    int            n_err = 0;
    int            cyc   = 0;
    bit [DW-1:0]   mprog [N_NODES];
    bit            exp_out;
    bit [TTW-1:0]  exp_tt;

    task automatic check(input string tag, input logic [TTW-1:0] got, input logic [TTW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    function automatic bit [DW-1:0] mk(int sa, int ia, int sb, int ib, int sc, int ic);
        int w;
        w = sa + (ia << SEL_W) + (sb << (SEL_W + 1)) + (ib << (2*SEL_W + 1))
              + (sc << (2*SEL_W + 2)) + (ic << (3*SEL_W + 2));
        return DW'(w);
    endfunction

    function automatic bit model_f(int unsigned x);
        bit node [N_NODES];
        int f, sel, v, cnt;
        for (int k = 0; k < N_NODES; k++) node[k] = 1'b0;
        for (int k = 0; k < N_NODES; k++) begin
            cnt = 0;
            for (int j = 0; j < 3; j++) begin
                f   = int'(mprog[k]) >> (j * (SEL_W + 1));
                sel = f % (1 << SEL_W);
                v   = (f >> SEL_W) & 1;
                if (sel >= 1 && sel <= N_IN)
                    v = v ^ int'((x >> (sel - 1)) & 1);
                else if (sel > N_IN && sel <= N_IN + N_NODES)
                    v = v ^ int'(node[sel - N_IN - 1]);
                cnt += v;
            end
            node[k] = (cnt >= 2);
        end
        return node[N_NODES-1];
    endfunction

    function automatic bit [TTW-1:0] model_tt();
        bit [TTW-1:0] t;
        for (int i = 0; i < TTW; i++) t[i] = model_f(i);
        return t;
    endfunction

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic cfg_write(input int addr, input bit [DW-1:0] data);
        @(negedge clk);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = AW'(addr);
        bus.cfg_data = data;
        @(negedge clk);
        bus.cfg_we   = 1'b0;
        if (addr < N_NODES) mprog[addr] = data;
    endtask

    // Optional same-edge program write alongside start.
    task automatic start_eval(input bit m, input int unsigned x, input bit wr,
                              input int addr, input bit [DW-1:0] data);
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = m;
        bus.x_in  = N_IN'(x);
        if (wr) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_addr = AW'(addr);
            bus.cfg_data = data;
            if (addr < N_NODES) mprog[addr] = data;
        end
        @(negedge clk);
        bus.start  = 1'b0;
        bus.cfg_we = 1'b0;
        // Scramble the request inputs: the DUT must have latched them.
        bus.mode   = ~m;
        bus.x_in   = N_IN'($urandom);
        cyc = 1;
        check("busy_c1", bus.busy, 1);
    endtask

    task automatic finish_eval(input bit m, input int unsigned x, input string tag);
        while (!bus.done && cyc < LIMIT) tick();
        check({tag, "_done"}, bus.done, 1);
        check({tag, "_lat"}, cyc, m ? LAT_SWEEP : LAT_SINGLE);
        if (m) begin
            exp_tt  = model_tt();
            exp_out = exp_tt[TTW-1];
        end else begin
            exp_out = model_f(x);
        end
        check({tag, "_out"}, bus.out_bit, exp_out);
        check({tag, "_tt"}, bus.tt, exp_tt);
        tick();
        check({tag, "_pulse"}, bus.done, 0);
        check({tag, "_idle"}, bus.busy, 0);
    endtask

    task automatic run(input bit m, input int unsigned x, input string tag);
        start_eval(m, x, 1'b0, 0, '0);
        finish_eval(m, x, tag);
    endtask

    bit [TTW-1:0] t1_tt;
    bit [TTW-1:0] want;
    int unsigned  xr;

    initial begin
        t1_tt = 128'hfeeaeac8eeeaeac0fca8a888eca8a880;
        rst_n = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
        bus.start = 1'b0;  bus.mode = 1'b0;   bus.x_in = '0;
        for (int k = 0; k < N_NODES; k++) mprog[k] = '0;
        exp_out = 1'b0;
        exp_tt  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_out", bus.out_bit, 0);
        check("rst_tt", bus.tt, 0);
        rst_n = 1'b1;

        // T1: reference program, sweep
        cfg_write(0, mk(1,0,4,0,5,0));
        cfg_write(1, mk(2,0,3,0,8,0));
        cfg_write(2, mk(2,0,6,0,9,0));
        cfg_write(3, mk(7,0,8,0,9,0));
        cfg_write(4, mk(1,0,10,0,11,0));
        run(1'b1, 0, "t1");
        check("t1_tt_const", bus.tt, t1_tt);
        check("t1_out_const", bus.out_bit, 1);

        // T2: single mode, tt must be left untouched
        run(1'b0, 7'b0000111, "t2a");
        check("t2a_const", bus.out_bit, 1);
        run(1'b0, 7'b0000101, "t2b");
        check("t2b_const", bus.out_bit, 0);
        check("t2_tt_hold", bus.tt, t1_tt);

        // T3: n4 = MAJ(0, x1, ~x2) = x1 & ~x2
        for (int k = 0; k < N_NODES - 1; k++) cfg_write(k, '0);
        cfg_write(4, mk(0,0,2,0,3,1));
        run(1'b1, 0, "t3");
        for (int i = 0; i < TTW; i++) want[i] = ((i >> 1) & 1) && !((i >> 2) & 1);
        check("t3_rule", bus.tt, want);
        check("t3_tt2", bus.tt[2], 1);
        check("t3_tt6", bus.tt[6], 0);

        // T4: self reference reads 0, inverted reads 1
        cfg_write(4, mk(12,0,1,0,2,0));
        run(1'b1, 0, "t4and");
        for (int i = 0; i < TTW; i++) want[i] = (i & 1) && ((i >> 1) & 1);
        check("t4and_rule", bus.tt, want);
        cfg_write(4, mk(12,1,1,0,2,0));
        run(1'b1, 0, "t4or");
        for (int i = 0; i < TTW; i++) want[i] = (i & 1) || ((i >> 1) & 1);
        check("t4or_rule", bus.tt, want);

        // Same-edge write and start: n4 = MAJ(x2, x2, 0) = x2
        xr = $urandom_range(0, TTW - 1);
        start_eval(1'b0, xr, 1'b1, 4, mk(3,0,3,0,0,0));
        finish_eval(1'b0, xr, "wr_start");
        check("wr_start_rule", bus.out_bit, (xr >> 2) & 1);

        // T5: start and cfg_we mid-sweep are ignored
        start_eval(1'b1, 0, 1'b0, 0, '0);
        repeat (100) tick();
        bus.start = 1'b1; bus.mode = 1'b0;
        bus.cfg_we = 1'b1; bus.cfg_addr = AW'(4); bus.cfg_data = mk(0,1,0,1,0,1);
        tick();
        bus.start = 1'b0; bus.cfg_we = 1'b0;
        finish_eval(1'b1, 0, "t5");
        repeat (5) tick();
        check("t5_no_extra_done", bus.done, 0);
        run(1'b0, 4, "t5_prog_kept");

        // Random programs, including out-of-range selects and dropped writes
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < N_NODES; k++)
                cfg_write(k, mk($urandom_range(0, 15), $urandom_range(0, 1),
                                $urandom_range(0, 15), $urandom_range(0, 1),
                                $urandom_range(0, 15), $urandom_range(0, 1)));
            cfg_write($urandom_range(N_NODES, 2**AW - 1), DW'($urandom));
            for (int s = 0; s < 3; s++) run(1'b0, $urandom_range(0, TTW - 1), "rnd_single");
            run(1'b1, 0, "rnd_sweep");
        end

        // T6: reset mid-sweep clears everything, no done
        start_eval(1'b1, 0, 1'b0, 0, '0);
        repeat (200) tick();
        #2 rst_n = 1'b0;
        #1;
        check("t6_busy", bus.busy, 0);
        check("t6_done", bus.done, 0);
        check("t6_tt", bus.tt, 0);
        check("t6_out", bus.out_bit, 0);
        for (int k = 0; k < N_NODES; k++) mprog[k] = '0;
        exp_tt  = '0;
        exp_out = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_no_done", bus.done, 0);
        run(1'b0, $urandom_range(0, TTW - 1), "t6_single");
        check("t6_cleared", bus.out_bit, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
